sim_controller: RTL and testbench
=================================

Name: sim_controller

Overview:
- Parametrised successor to the top-level cycle simulator control: sequences a simulated clock made of NUM_PHASES sub-phases per simulated cycle.
- Supports start, pause, single-step and a programmable run length.
- Exposes FSM state, current phase, simulated-cycle count, a per-cycle tick and a done flag.
- Sits at the top of the simulator and drives phase/cycle enables into the modelled components.

Parameters:
- CYCLE_WIDTH, 5, width of current_cycle and max_cycle.
- NUM_PHASES, 4, clock edges per simulated cycle; legal range >= 1.
- PHASE_WIDTH, derived as max(1, clog2(NUM_PHASES)), width of phase; localparam, not overridable.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin or resume run; level sampled on each edge.
- pause  in  1  request pause.
- step  in  1  advance exactly one simulated cycle while PAUSED.
- max_cycle  in  CYCLE_WIDTH  run length; latched when a run begins from IDLE or DONE.
- state  out  2  IDLE=0, RUN=1, PAUSED=2, DONE=3.
- phase  out  PHASE_WIDTH  current sub-phase, 0..NUM_PHASES-1.
- current_cycle  out  CYCLE_WIDTH  completed simulated cycles since run start.
- cycle_tick  out  1  one-clock pulse in the clock after current_cycle increments.
- done  out  1  high exactly while state==DONE.

Behaviour:
- Reset: state=IDLE, phase=0, current_cycle=0, cycle_tick=0, done=0, step_pending=0, max latch=0. Reset asserted mid-run takes effect at the next edge and overrides all other inputs.
- All outputs are registered. No combinational path from inputs to outputs.
- IDLE, start=1: latch max_cycle, clear phase and current_cycle.
  - If max_cycle==0, go to DONE; otherwise go to RUN.
- RUN, each edge with no pause:
  - phase increments.
  - When phase==NUM_PHASES-1: phase wraps to 0, current_cycle increments by 1 and cycle_tick=1 on the following clock.
  - With NUM_PHASES=1, every RUN edge is a cycle boundary.
- RUN, pause=1: go to PAUSED; phase and cycle are frozen and do not advance on that edge.
  - Exception: if that edge is a boundary whose new cycle == latched max, the boundary completes and the FSM goes to DONE. DONE takes priority over pause.
- RUN, boundary with new current_cycle == latched max: go to DONE and clear step_pending.
- PAUSED:
  - start=1: go to RUN. start has priority over step.
  - step=1 with start=0: set step_pending and go to RUN.
  - pause is ignored.
- Step: while step_pending=1, the FSM runs phases until the next cycle boundary, then returns to PAUSED and clears step_pending. If that boundary reaches max, it goes to DONE instead. pause during a step is honoured as in RUN and clears step_pending.
- DONE: outputs hold and done=1. start=1 re-latches max_cycle, clears phase and cycle, and behaves as start from IDLE.
- Counter width: current_cycle never wraps, because the run terminates at equality and max_cycle <= 2^CYCLE_WIDTH-1. Changes to the max_cycle input during a run have no effect.
- cycle_tick is 0 in every clock not immediately following an increment.

Decomposition:
- Package sim_ctrl_pkg: state encoding constants (ST_IDLE, ST_RUN, ST_PAUSED, ST_DONE) and a 2-bit state typedef. Shared with the bench.
- Sub-module sim_phase_counter (parameters NUM_PHASES, CYCLE_WIDTH):
  - Inputs: clear, enable.
  - Outputs: phase, current_cycle, boundary (combinational; high when phase==NUM_PHASES-1 and enable=1).
  - The top level holds the FSM, max latch, step_pending, tick and done.

Test Plan:
1. Basic run, CYCLE_WIDTH=5, NUM_PHASES=4, max_cycle=3: reset, then start for 1 clk.
   - state goes 1 on the next edge; phase sequence 0,1,2,3 repeats.
   - cycle_tick pulses 3 times, 4 clks apart; current_cycle goes 1,2,3.
   - state=3 and done=1 on the edge where cycle becomes 3, i.e. 12 clks after RUN entry.
2. Pause at phase=2 of cycle 1 for 5 clks: phase stays 2, cycle stays 1, state=2; start resumes at phase 3 with no lost or duplicated phase.
3. Step while PAUSED at phase=1: step for 1 clk.
   - State=1 for 3 clks, then 2, with phase=0, cycle incremented by 1 and one cycle_tick.
   - Second step at max-1 goes to state=3.
4. Edge cases:
   - start with max_cycle=0 goes straight to DONE with cycle=0 and no tick.
   - max_cycle=31 runs to 31 with no wrap and done=1.
   - Restart from DONE with max_cycle=2 clears to 0 and finishes at 2.
5. Simultaneous events:
   - pause on the final boundary: DONE wins.
   - start and step together in PAUSED: plain RUN, step_pending=0.
   - max_cycle input changed mid-run: no effect.
6. Reset asserted mid-RUN at cycle 2, phase 3: on the next edge all outputs are at reset values and start is ignored while reset=1. Repeat with NUM_PHASES=1, which must tick every RUN clock.

Source files
------------

// File: rtl/sim_controller_pkg.sv
// sim_ctrl_pkg: state encoding and width helper shared by the controller and its bench
package sim_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;
  function automatic int phase_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sim_controller_if.sv
// sim_controller_if: run-control inputs and status outputs of the simulated-clock controller
interface sim_controller_if
  import sim_ctrl_pkg::*;
#(
  parameter int CYCLE_WIDTH = 5,
  parameter int NUM_PHASES  = 4
);
  localparam int PHASE_WIDTH = phase_width(NUM_PHASES);
  logic                   start;
  logic                   pause;
  logic                   step;
  logic [CYCLE_WIDTH-1:0] max_cycle;
  state_t                 state;
  logic [PHASE_WIDTH-1:0] phase;
  logic [CYCLE_WIDTH-1:0] current_cycle;
  logic                   cycle_tick;
  logic                   done;
  modport master (
    output start, pause, step, max_cycle,
    input  state, phase, current_cycle, cycle_tick, done
  );
  modport slave (
    input  start, pause, step, max_cycle,
    output state, phase, current_cycle, cycle_tick, done
  );
endinterface

// File: rtl/sim_controller_phase_counter.sv
// sim_phase_counter: sub-phase counter that rolls over into a completed-cycle count
module sim_phase_counter
  import sim_ctrl_pkg::*;
#(
  parameter int NUM_PHASES  = 4,
  parameter int CYCLE_WIDTH = 5,
  localparam int PHASE_WIDTH = phase_width(NUM_PHASES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   enable,
  output logic [PHASE_WIDTH-1:0] phase,
  output logic [CYCLE_WIDTH-1:0] current_cycle,
  output logic                   boundary
);
  assign boundary = enable && phase == PHASE_WIDTH'(NUM_PHASES - 1);
  // advance one sub-phase per enabled clock, wrapping into the next cycle at the last phase
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      phase         <= '0;
      current_cycle <= '0;
    end else if (enable) begin
      phase         <= boundary ? '0 : phase + PHASE_WIDTH'(1);
      current_cycle <= current_cycle + CYCLE_WIDTH'(boundary);
    end
  end
endmodule

// File: rtl/sim_controller.sv
// sim_controller: run/pause/step FSM sequencing a multi-phase simulated clock up to a latched run length
module sim_controller
  import sim_ctrl_pkg::*;
#(
  parameter int CYCLE_WIDTH = 5,
  parameter int NUM_PHASES  = 4
) (
  input logic              clk,
  input logic              reset,
  sim_controller_if.slave  bus
);
  localparam int PHASE_WIDTH = phase_width(NUM_PHASES);
  logic [CYCLE_WIDTH-1:0] max_q;
  logic                   step_pending;
  logic                   fin;
  logic                   go;
  logic                   enable;
  logic                   boundary;
  // fin: the next boundary completes the run, so it must happen even under pause
  assign fin    = bus.phase == PHASE_WIDTH'(NUM_PHASES - 1) && bus.current_cycle + CYCLE_WIDTH'(1) == max_q;
  assign go     = bus.start && (bus.state == ST_IDLE || bus.state == ST_DONE);
  assign enable = bus.state == ST_RUN && (!bus.pause || fin);
  sim_phase_counter #(
    .NUM_PHASES (NUM_PHASES),
    .CYCLE_WIDTH(CYCLE_WIDTH)
  ) u_cnt (
    .clk          (clk),
    .reset        (reset),
    .clear        (go),
    .enable       (enable),
    .phase        (bus.phase),
    .current_cycle(bus.current_cycle),
    .boundary     (boundary)
  );
  // control FSM with run-length latch, single-step tracking and registered tick/done
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.state      <= ST_IDLE;
      bus.done       <= 1'b0;
      bus.cycle_tick <= 1'b0;
      step_pending   <= 1'b0;
      max_q          <= '0;
    end else begin
      bus.cycle_tick <= boundary;
      if (go) begin
        max_q        <= bus.max_cycle;
        bus.state    <= bus.max_cycle == '0 ? ST_DONE : ST_RUN;
        bus.done     <= bus.max_cycle == '0;
        step_pending <= 1'b0;
      end else if (bus.state == ST_RUN) begin
        if (boundary && fin) begin
          bus.state    <= ST_DONE;
          bus.done     <= 1'b1;
          step_pending <= 1'b0;
        end else if (bus.pause || (boundary && step_pending)) begin
          bus.state    <= ST_PAUSED;
          step_pending <= 1'b0;
        end
      end else if (bus.state == ST_PAUSED && (bus.start || bus.step)) begin
        bus.state    <= ST_RUN;
        step_pending <= !bus.start;
      end
    end
  end
endmodule

// File: tb/tb_sim_controller.sv
// tb_sim_controller: vector table, corner sequences and random run against a position-based model, for 4-phase and 1-phase builds
module tb_sim_controller;
  import sim_ctrl_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       step = 1'b0;
  logic [4:0] maxc = '0;
  int checks = 0;
  int errors = 0;
  sim_controller_if #(.CYCLE_WIDTH(5), .NUM_PHASES(4)) b4 ();
  sim_controller_if #(.CYCLE_WIDTH(5), .NUM_PHASES(1)) b1 ();
  assign b4.start = start;
  assign b4.pause = pause;
  assign b4.step = step;
  assign b4.max_cycle = maxc;
  assign b1.start = start;
  assign b1.pause = pause;
  assign b1.step = step;
  assign b1.max_cycle = maxc;
  sim_controller #(.CYCLE_WIDTH(5), .NUM_PHASES(4)) dut4 (.clk(clk), .reset(rst), .bus(b4));
  sim_controller #(.CYCLE_WIDTH(5), .NUM_PHASES(1)) dut1 (.clk(clk), .reset(rst), .bus(b1));
  // model: run progress is a single count of elapsed sub-phases since start
  localparam int NPS[2] = '{4, 1};
  int m_st[2], m_pos[2], m_mx[2], m_sp[2], m_tick[2];
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic model_step(input int k);
    int n;
    bit bnd, adv;
    n = NPS[k];
    if (rst) begin
      m_st[k] = 0; m_pos[k] = 0; m_mx[k] = 0; m_sp[k] = 0; m_tick[k] = 0;
    end else if (start && (m_st[k] == 0 || m_st[k] == 3)) begin
      m_mx[k] = maxc; m_pos[k] = 0; m_st[k] = maxc == 0 ? 3 : 1; m_sp[k] = 0; m_tick[k] = 0;
    end else if (m_st[k] == 1) begin
      bnd = (m_pos[k] + 1) % n == 0;
      adv = !pause || (bnd && (m_pos[k] + 1) / n == m_mx[k]);
      m_tick[k] = adv && bnd;
      if (adv) m_pos[k]++;
      if (adv && bnd && m_pos[k] / n == m_mx[k]) begin
        m_st[k] = 3; m_sp[k] = 0;
      end else if (pause || (adv && bnd && m_sp[k] != 0)) begin
        m_st[k] = 2; m_sp[k] = 0;
      end
    end else begin
      m_tick[k] = 0;
      if (m_st[k] == 2 && (start || step)) begin
        m_st[k] = 1; m_sp[k] = start ? 0 : 1;
      end
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check("p4 state", int'(b4.state), m_st[0]);
    check("p4 phase", int'(b4.phase), m_pos[0] % 4);
    check("p4 cycle", int'(b4.current_cycle), m_pos[0] / 4);
    check("p4 tick", int'(b4.cycle_tick), m_tick[0]);
    check("p4 done", int'(b4.done), int'(m_st[0] == 3));
    check("p1 state", int'(b1.state), m_st[1]);
    check("p1 phase", int'(b1.phase), 0);
    check("p1 cycle", int'(b1.current_cycle), m_pos[1]);
    check("p1 tick", int'(b1.cycle_tick), m_tick[1]);
    check("p1 done", int'(b1.done), int'(m_st[1] == 3));
  endtask
  typedef struct {
    bit r, s, p, t;
    int mx, st, ph, cy;
    bit tk;
  } vec_t;
  function automatic vec_t v(bit r, bit s, bit p, bit t, int mx, int st, int ph, int cy, bit tk);
    vec_t x;
    x.r = r; x.s = s; x.p = p; x.t = t; x.mx = mx; x.st = st; x.ph = ph; x.cy = cy; x.tk = tk;
    return x;
  endfunction
  initial begin
    vec_t vq[$];
    int ticks4, ticks1, n;
    bit found;
    vq.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(v(0, 1, 0, 0, 2, 1, 0, 0, 0));
    vq.push_back(v(0, 0, 0, 0, 0, 1, 1, 0, 0));
    vq.push_back(v(0, 0, 0, 0, 0, 1, 2, 0, 0));
    vq.push_back(v(0, 0, 1, 0, 0, 2, 2, 0, 0));
    vq.push_back(v(0, 0, 1, 0, 0, 2, 2, 0, 0));
    vq.push_back(v(0, 1, 0, 0, 0, 1, 2, 0, 0));
    vq.push_back(v(0, 0, 0, 0, 0, 1, 3, 0, 0));
    vq.push_back(v(0, 0, 0, 0, 0, 1, 0, 1, 1));
    vq.push_back(v(0, 0, 1, 0, 0, 2, 0, 1, 0));
    vq.push_back(v(0, 0, 0, 1, 0, 1, 0, 1, 0));
    vq.push_back(v(0, 0, 0, 0, 0, 1, 1, 1, 0));
    vq.push_back(v(0, 0, 0, 0, 0, 1, 2, 1, 0));
    vq.push_back(v(0, 0, 0, 0, 0, 1, 3, 1, 0));
    vq.push_back(v(0, 0, 0, 0, 0, 3, 0, 2, 1));
    vq.push_back(v(0, 0, 0, 0, 0, 3, 0, 2, 0));
    vq.push_back(v(0, 1, 0, 0, 0, 3, 0, 0, 0));
    vq.push_back(v(0, 1, 1, 0, 2, 1, 0, 0, 0));
    vq.push_back(v(0, 0, 1, 0, 0, 2, 0, 0, 0));
    vq.push_back(v(0, 1, 0, 1, 0, 1, 0, 0, 0));
    vq.push_back(v(0, 0, 0, 0, 0, 1, 1, 0, 0));
    vq.push_back(v(0, 0, 0, 0, 0, 1, 2, 0, 0));
    vq.push_back(v(0, 0, 0, 0, 0, 1, 3, 0, 0));
    vq.push_back(v(0, 0, 0, 0, 0, 1, 0, 1, 1));
    vq.push_back(v(0, 0, 0, 0, 9, 1, 1, 1, 0));
    vq.push_back(v(0, 0, 0, 0, 9, 1, 2, 1, 0));
    vq.push_back(v(0, 0, 0, 0, 9, 1, 3, 1, 0));
    vq.push_back(v(0, 0, 1, 0, 9, 3, 0, 2, 1));
    vq.push_back(v(1, 1, 0, 0, 3, 0, 0, 0, 0));
    foreach (vq[i]) begin
      rst = vq[i].r; start = vq[i].s; pause = vq[i].p; step = vq[i].t; maxc = 5'(vq[i].mx);
      cyc();
      check($sformatf("vec%0d state", i), int'(b4.state), vq[i].st);
      check($sformatf("vec%0d phase", i), int'(b4.phase), vq[i].ph);
      check($sformatf("vec%0d cycle", i), int'(b4.current_cycle), vq[i].cy);
      check($sformatf("vec%0d tick", i), int'(b4.cycle_tick), int'(vq[i].tk));
      check($sformatf("vec%0d done", i), int'(b4.done), int'(vq[i].st == 3));
    end
    rst = 0; start = 1; pause = 0; step = 0; maxc = 31;
    cyc();
    start = 0;
    ticks4 = 0; ticks1 = 0; n = 0;
    for (int i = 0; i < 200 && !b4.done; i++) begin
      cyc();
      n++;
      ticks4 += int'(b4.cycle_tick);
      ticks1 += int'(b1.cycle_tick);
    end
    check("max31 done", int'(b4.done), 1);
    check("max31 cycle", int'(b4.current_cycle), 31);
    check("max31 clocks", n, 124);
    check("max31 ticks p4", ticks4, 31);
    check("max31 ticks p1", ticks1, 31);
    start = 1; maxc = 10;
    cyc();
    start = 0;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      cyc();
      found = b4.current_cycle == 2 && b4.phase == 3;
    end
    check("reach cycle2 phase3", int'(found), 1);
    rst = 1; start = 1;
    cyc();
    check("rst state", int'(b4.state), 0);
    check("rst phase", int'(b4.phase), 0);
    check("rst cycle", int'(b4.current_cycle), 0);
    check("rst tick", int'(b4.cycle_tick), 0);
    check("rst done", int'(b4.done), 0);
    cyc();
    check("rst hold state", int'(b4.state), 0);
    check("rst hold p1 state", int'(b1.state), 0);
    rst = 0; start = 1; maxc = 5;
    cyc();
    start = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("p1 tick each clock", int'(b1.cycle_tick), 1);
    end
    rst = 1;
    cyc();
    check("p1 rst state", int'(b1.state), 0);
    check("p1 rst cycle", int'(b1.current_cycle), 0);
    rst = 0;
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 63) == 0;
      start = $urandom_range(0, 7) == 0;
      pause = $urandom_range(0, 5) == 0;
      step = $urandom_range(0, 4) == 0;
      maxc = $urandom_range(0, 7) == 0 ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
      cyc();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
